// File: rtl/modred_feeder.sv
// rtl/modred_feeder.sv - operand FIFO and issue sequencer for the serial modular reducer
// Optional watchdog on the reducer handshake is enabled by defining MODRED_WATCHDOG_EN.
module modred_feeder #(
    parameter int DATA_LENGTH    = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_we_i,
    input  logic [DATA_LENGTH-1:0] cfg_mod_i,
    output logic                   cfg_err_o,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] in_data_i,
    output logic                   red_start_o,
    output logic [DATA_LENGTH-1:0] red_x_o,
    output logic [DATA_LENGTH-1:0] red_m_o,
    output logic [DATA_LENGTH-1:0] red_m_bl_o,
    input  logic [DATA_LENGTH-1:0] red_result_i,
    input  logic                   red_valid_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] out_data_o,
    output logic                   busy_o,
    output logic                   error_o
);

    localparam int PW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("modred_feeder: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_LENGTH-1:0] m_q, m_d;
    logic [DATA_LENGTH-1:0] bl_q, bl_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [DATA_LENGTH-1:0] fifo_q [FIFO_DEPTH];
    logic [DATA_LENGTH-1:0] fifo_d [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]            cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0] x_q, x_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_LENGTH-1:0] out_data_q, out_data_d;

    logic                   fifo_full, fifo_empty, mod_ok, halt, busy;
    logic                   push, pop, wd_trip;
    logic [DATA_LENGTH-1:0] bl_calc;

    assign fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign mod_ok     = (m_q >= DATA_LENGTH'(2));
    assign busy       = !fifo_empty || (state_q != S_IDLE) || out_valid_q;
    assign push       = in_valid_i && in_ready_o;

`ifdef MODRED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            error_q, error_d;

    // Counts from the ISSUE cycle so the error lands TIMEOUT_CYCLES after the start pulse.
    assign wd_trip = (state_q == S_WAIT) && !red_valid_i
                     && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign halt    = error_q;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        error_d  = error_q | wd_trip;
        if (state_q == S_IDLE) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            error_q  <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign wd_trip = 1'b0;
    assign halt    = 1'b0;
    assign error_o = 1'b0;
`endif

    // Bitlength of the candidate modulus: index of the highest set bit plus one.
    always_comb begin
        bl_calc = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (cfg_mod_i[i]) begin
                bl_calc = DATA_LENGTH'(i + 1);
            end
        end
    end

    always_comb begin
        m_d       = m_q;
        bl_d      = bl_q;
        cfg_err_d = 1'b0;
        if (cfg_we_i) begin
            if (!busy && (cfg_mod_i >= DATA_LENGTH'(2))) begin
                m_d  = cfg_mod_i;
                bl_d = bl_calc;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        x_d         = x_q;
        out_valid_d = out_valid_q && !out_ready_i;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && (!out_valid_q || out_ready_i) && !halt) begin
                    pop     = 1'b1;
                    x_d     = fifo_q[rd_ptr_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (red_valid_i) begin
                    out_valid_d = 1'b1;
                    out_data_d  = red_result_i;
                    state_d     = S_IDLE;
                end else if (wd_trip) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = in_data_i;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            bl_q        <= '0;
            cfg_err_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            bl_q        <= bl_d;
            cfg_err_q   <= cfg_err_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign cfg_err_o   = cfg_err_q;
    assign in_ready_o  = !fifo_full && mod_ok && !halt;
    assign red_start_o = (state_q == S_ISSUE);
    assign red_x_o     = x_q;
    assign red_m_o     = m_q;
    assign red_m_bl_o  = bl_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy;

endmodule

// File: tb/tb_modred_feeder.sv
// tb/tb_modred_feeder.sv - directed self-checking bench for modred_feeder
module tb_modred_feeder;

    localparam int DL    = 64;
    localparam int DELAY = 7;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          cfg_we_i;
    logic [DL-1:0] cfg_mod_i;
    logic          cfg_err_o;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DL-1:0] in_data_i;
    logic          red_start_o;
    logic [DL-1:0] red_x_o, red_m_o, red_m_bl_o;
    logic [DL-1:0] red_result_i;
    logic          red_valid_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DL-1:0] out_data_o;
    logic          busy_o;
    logic          error_o;

    always #5 clk = ~clk;

    modred_feeder dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cfg_we_i     (cfg_we_i),
        .cfg_mod_i    (cfg_mod_i),
        .cfg_err_o    (cfg_err_o),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .red_start_o  (red_start_o),
        .red_x_o      (red_x_o),
        .red_m_o      (red_m_o),
        .red_m_bl_o   (red_m_bl_o),
        .red_result_i (red_result_i),
        .red_valid_i  (red_valid_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .busy_o       (busy_o),
        .error_o      (error_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DL-1:0] got, input logic [DL-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reducer model: answers x mod m DELAY cycles after a start pulse.
    bit            respond = 1'b1;
    bit            mbusy   = 1'b0;
    logic [DL-1:0] mx, mm;
    int            mcnt;
    int            starts = 0, wait_starts = 0, x_unstable = 0;
    int            start_cyc = 0, valid_cyc = 0;

    initial begin
        red_valid_i  = 1'b0;
        red_result_i = '0;
        forever begin
            @(negedge clk);
            red_valid_i = 1'b0;
            if (!rst_ni) begin
                mbusy = 1'b0;
            end else if (mbusy) begin
                if (red_x_o !== mx) x_unstable++;
                if (red_start_o) wait_starts++;
                if (respond && mcnt == 1) begin
                    red_valid_i  = 1'b1;
                    red_result_i = mx % mm;
                    valid_cyc    = cyc;
                    mbusy        = 1'b0;
                end else if (mcnt > 1) begin
                    mcnt--;
                end
            end else if (red_start_o) begin
                mbusy     = 1'b1;
                mx        = red_x_o;
                mm        = red_m_o;
                mcnt      = DELAY;
                starts++;
                start_cyc = cyc;
            end
        end
    end

    logic [DL-1:0] got_q[$];
    int            out_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_ni && out_valid_o && out_ready_i) begin
                got_q.push_back(out_data_o);
                out_cyc = cyc;
            end
        end
    end

    int acc_cyc = 0;

    task automatic push(input logic [DL-1:0] x);
        int t = 0;
        in_valid_i = 1'b1;
        in_data_i  = x;
        while (!in_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("push_timeout", 64'(t), 64'(0));
        acc_cyc = cyc;
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic cfg_write(input logic [DL-1:0] m, output logic err);
        cfg_we_i  = 1'b1;
        cfg_mod_i = m;
        @(negedge clk);
        cfg_we_i  = 1'b0;
        err       = cfg_err_o;
    endtask

    task automatic wait_results(input int n, input string tag);
        int t = 0;
        while (got_q.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(got_q.size()), 64'(n));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("wait_idle", 64'(busy_o), 64'(0));
    endtask

    task automatic wait_start(input int n);
        int t = 0;
        while (starts < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("wait_start", 64'(starts), 64'(n));
    endtask

    logic [DL-1:0] xs2 [6] = '{64'd5, 64'd8380417, 64'd8380418, 64'd20000000, 64'd16760834, 64'd123456789};
    logic [DL-1:0] ex2 [6] = '{64'd5, 64'd0, 64'd1, 64'd3239166, 64'd0, 64'd6130951};

    initial begin
        logic          e;
        logic [DL-1:0] d0;
        bit            hold;
        int            stall_idx;
        int            t;

        rst_ni      = 1'b0;
        cfg_we_i    = 1'b0;
        cfg_mod_i   = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready_o), 64'(0));
        check("rst_red_m", red_m_o, 64'(0));
        check("rst_red_bl", red_m_bl_o, 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_out_valid", 64'(out_valid_o), 64'(0));
        check("rst_start", 64'(red_start_o), 64'(0));
        check("rst_cfg_err", 64'(cfg_err_o), 64'(0));
        check("rst_error", 64'(error_o), 64'(0));
        rst_ni = 1'b1;
        @(negedge clk);
        check("no_mod_in_ready", 64'(in_ready_o), 64'(0));

        // 1: single job, m = 3329
        cfg_write(64'd3329, e);
        check("t1_cfg_err", 64'(e), 64'(0));
        check("t1_bl", red_m_bl_o, 64'd12);
        check("t1_m", red_m_o, 64'd3329);
        check("t1_in_ready", 64'(in_ready_o), 64'(1));
        push(64'd10000);
        wait_results(1, "t1_results");
        check("t1_out", got_q[0], 64'd13);
        check("t1_starts", 64'(starts), 64'(1));
        check("t1_start_latency", 64'(start_cyc - acc_cyc), 64'(2));
        check("t1_out_latency", 64'(out_cyc - valid_cyc), 64'(1));
        wait_idle();

        // 2: burst of 6 operands
        cfg_write(64'd8380417, e);
        check("t2_bl", red_m_bl_o, 64'd23);
        got_q.delete();
        starts    = 0;
        stall_idx = -1;
        for (int i = 0; i < 6; i++) begin
            if (!in_ready_o && stall_idx < 0) stall_idx = i;
            push(xs2[i]);
        end
        check("t2_stall_index", 64'(stall_idx), 64'(5));
        wait_results(6, "t2_results");
        for (int i = 0; i < 6; i++) check($sformatf("t2_out%0d", i), got_q[i], ex2[i]);
        check("t2_starts", 64'(starts), 64'(6));
        check("t2_start_in_wait", 64'(wait_starts), 64'(0));
        wait_idle();

        // 3: all-ones operand against two moduli
        cfg_write(64'd65537, e);
        check("t3_bl17", red_m_bl_o, 64'd17);
        got_q.delete();
        push(64'hFFFF_FFFF_FFFF_FFFF);
        wait_results(1, "t3a_results");
        check("t3_out_65537", got_q[0], 64'd0);
        wait_idle();
        cfg_write(64'h7FFF_FFFF, e);
        check("t3_bl31", red_m_bl_o, 64'd31);
        got_q.delete();
        push(64'hFFFF_FFFF_FFFF_FFFF);
        wait_results(1, "t3b_results");
        check("t3_out_mersenne", got_q[0], 64'd3);
        check("t3_x_stable", 64'(x_unstable), 64'(0));
        wait_idle();

        // 4: output backpressure with two jobs queued
        out_ready_i = 1'b0;
        got_q.delete();
        starts = 0;
        push(64'd100);
        push(64'h8000_0000);
        t = 0;
        while (!out_valid_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        d0   = out_data_o;
        hold = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid_o || out_data_o !== d0) hold = 1'b0;
        end
        check("t4_hold", 64'(hold), 64'(1));
        check("t4_held_data", d0, 64'd100);
        check("t4_starts_held", 64'(starts), 64'(1));
        out_ready_i = 1'b1;
        wait_results(2, "t4_results");
        check("t4_out0", got_q[0], 64'd100);
        check("t4_out1", got_q[1], 64'd1);
        check("t4_starts", 64'(starts), 64'(2));
        wait_idle();

        // 5: rejected config writes, then reset mid-WAIT
        got_q.delete();
        push(64'd5);
        cfg_write(64'd3329, e);
        check("t5_busy_err", 64'(e), 64'(1));
        check("t5_busy_m", red_m_o, 64'h7FFF_FFFF);
        @(negedge clk);
        check("t5_err_pulse", 64'(cfg_err_o), 64'(0));
        wait_results(1, "t5_results");
        wait_idle();
        cfg_write(64'd1, e);
        check("t5_small_err", 64'(e), 64'(1));
        check("t5_small_m", red_m_o, 64'h7FFF_FFFF);
        check("t5_small_bl", red_m_bl_o, 64'd31);
        starts = 0;
        push(64'd7);
        wait_start(1);
        repeat (3) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("t5_rst_x", red_x_o, 64'(0));
        check("t5_rst_m", red_m_o, 64'(0));
        check("t5_rst_bl", red_m_bl_o, 64'(0));
        check("t5_rst_in_ready", 64'(in_ready_o), 64'(0));
        check("t5_rst_busy", 64'(busy_o), 64'(0));
        check("t5_rst_out_valid", 64'(out_valid_o), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("t5_post_in_ready", 64'(in_ready_o), 64'(0));
        check("t5_post_busy", 64'(busy_o), 64'(0));

        // 6: reducer never answers
        cfg_write(64'd3329, e);
        respond = 1'b0;
        starts  = 0;
        push(64'd9);
        wait_start(1);
`ifdef MODRED_WATCHDOG_EN
        t = 0;
        while (!error_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t6_error", 64'(error_o), 64'(1));
        check("t6_error_delay", 64'(cyc - start_cyc), 64'(64));
        check("t6_in_ready", 64'(in_ready_o), 64'(0));
        repeat (5) @(negedge clk);
        check("t6_no_restart", 64'(starts), 64'(1));
`else
        repeat (100) @(negedge clk);
        check("t6_error_tied", 64'(error_o), 64'(0));
        check("t6_still_busy", 64'(busy_o), 64'(1));
`endif
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni  = 1'b1;
        respond = 1'b1;
        @(negedge clk);
        check("t6_rst_error", 64'(error_o), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/modred_feeder.md
Name: modred_feeder

Overview:
- Upstream sequencer for the serial shift-add modular reducer.
- Accepts a valid/ready stream of 64-bit operands, buffers them in a small FIFO, and issues them one at a time to the reducer.
- Drives the reducer with a one-cycle start pulse, a stable operand, the modulus and the modulus bitlength. Captures the reducer result on its valid flag and presents it on a valid/ready output.
- Owns modulus configuration and bitlength computation, so the arithmetic datapath never sees an unstable m.

Parameters:
- DATA_LENGTH, 64, operand/modulus/result width.
- FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_we_i  in  1  modulus write strobe
- cfg_mod_i  in  DATA_LENGTH  modulus value
- cfg_err_o  out  1  one-cycle pulse: config write rejected
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  FIFO not full
- in_data_i  in  DATA_LENGTH  operand x
- red_start_o  out  1  reducer start pulse
- red_x_o  out  DATA_LENGTH  operand to reducer
- red_m_o  out  DATA_LENGTH  modulus to reducer
- red_m_bl_o  out  DATA_LENGTH  modulus bitlength to reducer
- red_result_i  in  DATA_LENGTH  reducer result
- red_valid_i  in  1  reducer result valid
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  DATA_LENGTH  reduced result
- busy_o  out  1  FIFO non-empty, or FSM not IDLE, or output register full
- error_o  out  1  sticky watchdog error (optional feature)

Behaviour:
Reset values:
- Every output is 0.
- Modulus register is 0, so bitlength is 0.
- FIFO is empty; FSM is in IDLE.
- Because the modulus is 0, in_ready_o stays 0 until a valid modulus has been written.

Configuration:
- cfg_we_i is accepted only when busy_o=0 and cfg_mod_i >= 2.
- On accept: m_reg <= cfg_mod_i; bl_reg <= (index of MSB of cfg_mod_i) + 1, computed by a priority encoder and registered.
- On reject (busy, or modulus < 2): registers unchanged; cfg_err_o pulses high the next cycle.

Input handshake and FIFO:
- A beat transfers when in_valid_i && in_ready_o.
- in_ready_o = !fifo_full && (m_reg >= 2).
- Simultaneous FIFO push and pop while full is not allowed (ready is already low). Simultaneous push and pop otherwise keeps the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM:
- IDLE -> ISSUE when the FIFO is non-empty and the output register is empty or draining this cycle (out_valid_o && out_ready_i). On this transition: pop the FIFO head into x_reg.
- ISSUE: red_start_o=1 for exactly this cycle. -> WAIT.
- WAIT: red_start_o=0; red_x_o, red_m_o and red_m_bl_o are held stable. On red_valid_i: out_data_o <= red_result_i, out_valid_o <= 1, -> IDLE.
- red_valid_i outside WAIT is ignored.

Datapath stability:
- red_x_o = x_reg, red_m_o = m_reg, red_m_bl_o = bl_reg. All are registers.
- x_reg changes only on the IDLE->ISSUE transition.

Output:
- out_valid_o stays high, and out_data_o stays stable, until out_ready_i.
- At most one job is ever outstanding at the reducer.

Latency:
- Input accepted in cycle t (FIFO empty, FSM idle): red_start_o high at t+2.
- out_valid_o rises the cycle after red_valid_i.

Asynchronous reset mid-operation:
- Drops all FIFO contents and any in-flight job.
- Modulus is cleared to 0.
- The reducer must be reset by the same rst_ni.

Optional Feature:
MODRED_WATCHDOG_EN
- Defined:
  - A counter runs in WAIT. If it reaches TIMEOUT_CYCLES without red_valid_i, error_o is set (sticky until reset), the job is discarded, and the FSM returns to IDLE.
  - While error_o=1, in_ready_o=0 and no further starts are issued.
- Undefined:
  - No counter; WAIT lasts indefinitely.
  - error_o is tied to 0.

Test Plan:
1. Write cfg_mod=3329 while idle -> red_m_bl_o=12, no cfg_err_o. Send x=10000 with the reducer model returning x mod m after 7 cycles -> exactly one red_start_o pulse; out_data_o=13.
2. cfg_mod=8380417; burst of 6 operands with out_ready_i=1 -> in_ready_o low after 4 queued while the first job is in flight; results in order; one start per operand; no start while in WAIT.
3. cfg_mod=65537 (bl 17) and cfg_mod=0x7FFFFFFF (bl 31): x=0xFFFFFFFFFFFFFFFF -> out_data_o = x mod m. red_x_o is constant from start until red_valid_i.
4. Backpressure: out_ready_i=0 for 20 cycles with 2 jobs queued -> out_valid_o held with stable data; second red_start_o only after the first output handshake.
5. cfg_we_i during a busy period, or with cfg_mod=1 -> cfg_err_o pulse; red_m_o unchanged. Assert rst_ni mid-WAIT -> all outputs 0, FIFO empty, in_ready_o=0.
6. With MODRED_WATCHDOG_EN and a reducer model that never responds -> error_o=1 at TIMEOUT_CYCLES=64 cycles after start; in_ready_o=0 afterwards.
